// File: rtl/fc_layer_engine.sv
// fc_layer_engine: NUM_NEURONS fixed-point neurons sharing one input stream.
// Each neuron accumulates PREVIOUS_LAYER_HEIGHT weighted inputs, adds its
// bias, optionally applies ReLU and saturates back to WORD_SIZE. Weights and
// biases live in an internal register file loaded through the wr_* port.
module fc_layer_engine #(
    parameter int WORD_SIZE             = 16,
    parameter int INT_BITS              = 8,
    parameter int PREVIOUS_LAYER_HEIGHT = 4,
    parameter int NUM_NEURONS           = 4,
    localparam int NEURON_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int ADDR_W   = $clog2(PREVIOUS_LAYER_HEIGHT + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              clear_i,
    input  logic                              relu_en_i,
    input  logic signed [WORD_SIZE-1:0]       data_i,
    input  logic                              data_valid_i,
    output logic                              data_ready_o,
    input  logic                              wr_en_i,
    input  logic [NEURON_W-1:0]               wr_neuron_i,
    input  logic [ADDR_W-1:0]                 wr_addr_i,
    input  logic [WORD_SIZE-1:0]              wr_data_i,
    output logic [NUM_NEURONS*WORD_SIZE-1:0]  data_o,
    output logic                              data_valid_o,
    input  logic                              data_ready_i
);

    localparam int H      = PREVIOUS_LAYER_HEIGHT;
    localparam int FRAC   = WORD_SIZE - INT_BITS;
    localparam int PROD_W = 2 * WORD_SIZE;
    // Headroom of clog2(H+1) bits means H full-scale products plus the bias
    // can never wrap the accumulator.
    localparam int ACC_W  = PROD_W + ADDR_W;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(H - 1);
    localparam logic [ADDR_W-1:0] BIAS_IDX = ADDR_W'(H);

    localparam logic [WORD_SIZE-1:0] WORD_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic [WORD_SIZE-1:0] WORD_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_BIAS,
        ST_OUT
    } state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       count;
    logic signed [ACC_W-1:0] acc [NUM_NEURONS];

    // Per neuron: H weights at indices 0..H-1, bias at index H.
    logic [WORD_SIZE-1:0]    coef_mem [NUM_NEURONS][H+1];

    // Combinational datapath values, one per neuron.
    logic signed [WORD_SIZE-1:0] weight    [NUM_NEURONS];
    logic signed [WORD_SIZE-1:0] bias      [NUM_NEURONS];
    logic signed [PROD_W-1:0]    prod      [NUM_NEURONS];
    logic signed [ACC_W-1:0]     acc_next  [NUM_NEURONS];
    logic signed [ACC_W-1:0]     bias_ext  [NUM_NEURONS];
    logic signed [ACC_W-1:0]     biased    [NUM_NEURONS];
    logic signed [ACC_W-1:0]     shifted   [NUM_NEURONS];
    logic signed [ACC_W-1:0]     rectified [NUM_NEURONS];
    logic [WORD_SIZE-1:0]        result    [NUM_NEURONS];

    logic neuron_ok;
    logic addr_ok;
    logic coef_we;

    // ---------------------------------------------------------------------
    // Write-port range decode. A comparison is only built when the port is
    // wide enough to name an index that does not exist.
    // ---------------------------------------------------------------------
    if ((2 ** NEURON_W) > NUM_NEURONS) begin : g_neuron_guard
        assign neuron_ok = ({1'b0, wr_neuron_i} < (NEURON_W+1)'(NUM_NEURONS));
    end else begin : g_neuron_full
        assign neuron_ok = 1'b1;
    end

    if ((2 ** ADDR_W) > (H + 1)) begin : g_addr_guard
        assign addr_ok = (wr_addr_i <= BIAS_IDX);
    end else begin : g_addr_full
        assign addr_ok = 1'b1;
    end

    assign coef_we = wr_en_i & neuron_ok & addr_ok;

    // Weight/bias register file write; contents survive reset.
    // NOTE: the coefficient store has no reset branch on purpose -- it is
    // loaded by software, and resetting a memory array forces every cell to
    // become a resettable flop with a wide reset fan-out for no benefit.
    always_ff @(posedge clk_i) begin
        if (coef_we) begin
            coef_mem[wr_neuron_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Multiply-accumulate and bias/ReLU/saturation datapath for every neuron.
    // NOTE: each variable gets a value on every pass through this block
    // before any conditional override; a path that skips an assignment
    // would infer a latch.
    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            weight[n] = coef_mem[n][count];
            bias[n]   = coef_mem[n][BIAS_IDX];

            // Full-precision signed product, sign-extended into the accumulator.
            prod[n]     = data_i * weight[n];
            acc_next[n] = acc[n] + {{(ACC_W-PROD_W){prod[n][PROD_W-1]}}, prod[n]};

            // Align the bias to the product's binary point (2*FRAC fraction bits).
            bias_ext[n] = {{(ACC_W-WORD_SIZE){bias[n][WORD_SIZE-1]}}, bias[n]} <<< FRAC;
            biased[n]   = acc[n] + bias_ext[n];

            // Arithmetic shift back to FRAC fraction bits rounds toward -inf.
            shifted[n] = biased[n] >>> FRAC;

            rectified[n] = shifted[n];
            if (relu_en_i && shifted[n][ACC_W-1]) begin
                rectified[n] = '0;
            end

            // Everything above the output sign bit must equal the sign,
            // otherwise the value is out of range for the output word.
            result[n] = rectified[n][WORD_SIZE-1:0];
            if (rectified[n][ACC_W-1:WORD_SIZE-1] !=
                {(ACC_W-WORD_SIZE+1){rectified[n][ACC_W-1]}}) begin
                result[n] = rectified[n][ACC_W-1] ? WORD_MIN : WORD_MAX;
            end
        end
    end

    // Frame sequencer: accumulate H inputs, fold in bias, present results.
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state  <= ST_ACCUM;
            count  <= '0;
            data_o <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                acc[n] <= '0;
            end
        end else if (clear_i) begin
            // Abort wins over any handshake in flight; results are kept.
            state <= ST_ACCUM;
            count <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                acc[n] <= '0;
            end
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (data_valid_i) begin
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            acc[n] <= acc_next[n];
                        end
                        if (count == LAST_IDX) begin
                            count <= '0;
                            state <= ST_BIAS;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end

                ST_BIAS: begin
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        data_o[n*WORD_SIZE +: WORD_SIZE] <= result[n];
                    end
                    state <= ST_OUT;
                end

                ST_OUT: begin
                    if (data_ready_i) begin
                        state <= ST_ACCUM;
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            acc[n] <= '0;
                        end
                    end
                end

                default: begin
                    state <= ST_ACCUM;
                    count <= '0;
                end
            endcase
        end
    end

    // Handshake outputs decode registered state only; ready drops with reset.
    assign data_ready_o = (state == ST_ACCUM) & ~reset_i;
    assign data_valid_o = (state == ST_OUT);

endmodule
